// File: rtl/rom_loader.sv
// rom_loader: cartridge download front end between data_io and the SDRAM
// write port. Each downloaded byte becomes one SDRAM write, issued as a
// toggle on mem_we and completed when mem_we_ack matches it. data_io is
// stalled with ioctl_wait while a write is outstanding.
//
// The block also produces:
//   - cart_mask: the OR of every written address, used as the ROM mirror mask.
//   - romhdr: set when the image carries a 512-byte header.
//   - byte_cnt: the number of bytes accepted.
//   - sys_reset: a core reset stretched RST_HOLD cycles past the download.
//
// Ports
//   clk_sys, RESET_n   clock, asynchronous active-low reset
//   ioctl_download     high for the whole download
//   ioctl_wr/dout      byte strobe and data
//   ioctl_wait         stall while an SDRAM write is outstanding
//   mem_waddr/din/we   SDRAM write address, data, request toggle
//   mem_we_ack         SDRAM ack toggle (write done when equal to mem_we)
//   cart_mask          OR of all written addresses (AW bits)
//   romhdr             image has a 512-byte header
//   byte_cnt           bytes accepted in the current/last download
//   err                sticky: a byte was dropped (overrun/overflow)
//   done               one-cycle pulse at the end of a completed download
//   sys_reset          core reset, high during download + RST_HOLD cycles
module rom_loader #(
  parameter int AW       = 22,
  parameter int RST_HOLD = 16
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [23:0]   mem_waddr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic          mem_we_ack,
  output logic [AW-1:0] cart_mask,
  output logic          romhdr,
  output logic [24:0]   byte_cnt,
  output logic          err,
  output logic          done,
  output logic          sys_reset
);

  typedef enum logic [2:0] {IDLE, START, RECV, WRITE, DRAIN, HOLD, DONE} state_t;

  localparam int            HW        = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [24:0]   MAX_CNT   = 25'(1) << AW;

  state_t        state, state_nxt;
  logic          dl_q;
  logic          restart_q;
  logic [HW-1:0] hold_cnt;

  logic rise, ack_ok, full, take;

  assign rise   = ioctl_download & ~dl_q;
  assign ack_ok = (mem_we_ack == mem_we);
  // Once 2^AW bytes are in, further bytes are dropped rather than wrapping.
  assign full   = (byte_cnt == MAX_CNT);
  assign take   = (state == RECV) && ioctl_wr && !full;

  // state register
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (rise) state_nxt = START;
      START: state_nxt = RECV;
      RECV: begin
        // A byte arriving as download falls is still written, then drained.
        if (take)                 state_nxt = ioctl_download ? WRITE : DRAIN;
        else if (!ioctl_download) state_nxt = HOLD;
      end
      WRITE, DRAIN: begin
        if (ack_ok) begin
          // A restart seen while the write was in flight skips HOLD/DONE.
          if (restart_q || rise)                      state_nxt = START;
          else if (state == WRITE && ioctl_download)  state_nxt = RECV;
          else                                        state_nxt = HOLD;
        end else if (!ioctl_download) begin
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (rise)                       state_nxt = START;
        else if (hold_cnt == HOLD_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = rise ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    ioctl_wait = (state == WRITE) || (state == DRAIN);
    done       = (state == DONE);
    sys_reset  = (state != IDLE) && (state != DONE);
  end

  // datapath
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      dl_q      <= 1'b0;
      restart_q <= 1'b0;
      hold_cnt  <= '0;
      mem_waddr <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      cart_mask <= '0;
      romhdr    <= 1'b0;
      byte_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      unique case (state)
        START: begin
          restart_q <= 1'b0;
          mem_waddr <= '0;
          cart_mask <= '0;
          romhdr    <= 1'b0;
          byte_cnt  <= '0;
          err       <= 1'b0;
        end
        RECV: begin
          if (ioctl_wr) begin
            if (full) begin
              err <= 1'b1;
            end else begin
              mem_din   <= ioctl_dout;
              mem_we    <= ~mem_we;
              cart_mask <= cart_mask | mem_waddr[AW-1:0];
            end
          end
        end
        WRITE, DRAIN: begin
          if (ioctl_wr) err <= 1'b1;        // overrun: byte dropped
          if (rise)     restart_q <= 1'b1;
          if (ack_ok) begin
            mem_waddr <= mem_waddr + 24'd1;
            byte_cnt  <= byte_cnt + 25'd1;
          end
        end
        // byte_cnt is frozen in HOLD, so latching every cycle equals latching on entry.
        HOLD:    romhdr <= byte_cnt[9];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed testbench for rom_loader: one task per scenario, inline checks.
module tb_rom_loader;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic RESET_n;

  // main instance (AW=22)
  logic        dl, wr, ack;
  logic [7:0]  dout;
  logic        ioctl_wait, mem_we, romhdr, err, done, sys_reset;
  logic [23:0] mem_waddr;
  logic [7:0]  mem_din;
  logic [21:0] cart_mask;
  logic [24:0] byte_cnt;

  // small instance (AW=4) for the overflow case
  logic        dl4, wr4, ack4;
  logic [7:0]  dout4;
  logic        wait4, we4, romhdr4, err4, done4, sysrst4;
  logic [23:0] waddr4;
  logic [7:0]  din4;
  logic [3:0]  mask4;
  logic [24:0] cnt4;

  rom_loader #(.AW(22), .RST_HOLD(16)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_dout(dout), .ioctl_wait(ioctl_wait), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_we_ack(ack), .cart_mask(cart_mask),
    .romhdr(romhdr), .byte_cnt(byte_cnt), .err(err), .done(done),
    .sys_reset(sys_reset));

  rom_loader #(.AW(4), .RST_HOLD(16)) dut4 (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_download(dl4), .ioctl_wr(wr4),
    .ioctl_dout(dout4), .ioctl_wait(wait4), .mem_waddr(waddr4),
    .mem_din(din4), .mem_we(we4), .mem_we_ack(ack4), .cart_mask(mask4),
    .romhdr(romhdr4), .byte_cnt(cnt4), .err(err4), .done(done4),
    .sys_reset(sysrst4));

  int n_chk = 0;
  int n_fail = 0;
  int ack_dly = 3;

  // SDRAM-side ack models: return the toggle ack_dly cycles after seeing it
  logic we_prev, we_prev4;
  int   ack_t, ack_t4;
  always @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      ack <= 1'b0; we_prev <= 1'b0; ack_t <= 0;
      ack4 <= 1'b0; we_prev4 <= 1'b0; ack_t4 <= 0;
    end else begin
      we_prev <= mem_we;
      if (mem_we != we_prev)  ack_t <= ack_dly;
      else if (ack_t == 1)    begin ack <= mem_we; ack_t <= 0; end
      else if (ack_t > 1)     ack_t <= ack_t - 1;
      we_prev4 <= we4;
      if (we4 != we_prev4)    ack_t4 <= 3;
      else if (ack_t4 == 1)   begin ack4 <= we4; ack_t4 <= 0; end
      else if (ack_t4 > 1)    ack_t4 <= ack_t4 - 1;
    end
  end

  // monitors: toggle counts, last write address/data, done pulses
  logic        we_n = 1'b0, we4_n = 1'b0;
  int          tog = 0, tog4 = 0, done_cnt = 0;
  logic [23:0] last_addr = '0;
  logic [7:0]  last_din = '0;
  always @(negedge clk_sys) begin
    we_n  <= mem_we;
    we4_n <= we4;
    if (mem_we !== we_n) begin
      tog <= tog + 1; last_addr <= mem_waddr; last_din <= mem_din;
    end
    if (we4 !== we4_n) tog4 <= tog4 + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // after this the DUT sits in RECV
  task automatic start_dl();
    dl = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  // send n bytes (data i*7+3, address i); bad counts data/address/stall errors
  task automatic send_n(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      wr = 1'b1; dout = 8'(i * 7 + 3);
      @(negedge clk_sys);
      wr = 1'b0;
      if (mem_din !== 8'(i * 7 + 3) || mem_waddr !== 24'(i) || ioctl_wait !== 1'b1) bad++;
      while (ioctl_wait && k < 100) begin @(negedge clk_sys); k++; end
      if (ioctl_wait) bad++;
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 200) begin @(negedge clk_sys); k++; end
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: timeout, done=%b want 1", name, done); end
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; dl = 0; wr = 0; dout = 0; dl4 = 0; wr4 = 0; dout4 = 0;
    repeat (3) @(negedge clk_sys);
    n_chk++;
    if ({ioctl_wait, mem_we, romhdr, err, done, sys_reset} !== 6'b0) begin
      n_fail++; $display("FAIL reset flags: got %b want 000000", {ioctl_wait, mem_we, romhdr, err, done, sys_reset});
    end
    n_chk++;
    if (mem_waddr !== 24'd0 || mem_din !== 8'd0) begin
      n_fail++; $display("FAIL reset mem: waddr=%h din=%h want 0", mem_waddr, mem_din);
    end
    n_chk++;
    if (cart_mask !== 22'd0 || byte_cnt !== 25'd0) begin
      n_fail++; $display("FAIL reset mask/cnt: mask=%h cnt=%0d want 0", cart_mask, byte_cnt);
    end
    RESET_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_1024();
    int bad, t0, d0;
    t0 = tog; d0 = done_cnt;
    start_dl();
    n_chk++;
    if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL t1024 sys_reset: got %b want 1", sys_reset); end
    send_n(1024, bad);
    dl = 1'b0;
    wait_done("t1024");
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL t1024 data: %0d bad writes want 0", bad); end
    n_chk++;
    if (tog - t0 != 1024) begin n_fail++; $display("FAIL t1024 toggles: got %0d want 1024", tog - t0); end
    n_chk++;
    if (byte_cnt !== 25'd1024) begin n_fail++; $display("FAIL t1024 byte_cnt: got %0d want 1024", byte_cnt); end
    n_chk++;
    if (cart_mask !== 22'h3FF) begin n_fail++; $display("FAIL t1024 cart_mask: got %h want 3ff", cart_mask); end
    n_chk++;
    if (romhdr !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL t1024 romhdr/err: got %b%b want 00", romhdr, err); end
    n_chk++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL t1024 done pulses: got %0d want 1", done_cnt - d0); end
    n_chk++;
    if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL t1024 sys_reset idle: got %b want 0", sys_reset); end
  endtask

  task automatic test_header();
    int bad;
    start_dl();
    send_n(1536, bad);
    dl = 1'b0;
    wait_done("hdr");
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL hdr data: %0d bad writes want 0", bad); end
    n_chk++;
    if (romhdr !== 1'b1) begin n_fail++; $display("FAIL hdr romhdr: got %b want 1", romhdr); end
    // OR of addresses 0..0x5FF covers bits 0-10
    n_chk++;
    if (cart_mask !== 22'h7FF) begin n_fail++; $display("FAIL hdr cart_mask: got %h want 7ff", cart_mask); end
    n_chk++;
    if (last_addr !== 24'h5FF) begin n_fail++; $display("FAIL hdr last waddr: got %h want 5ff", last_addr); end
    n_chk++;
    if (byte_cnt !== 25'd1536) begin n_fail++; $display("FAIL hdr byte_cnt: got %0d want 1536", byte_cnt); end
  endtask

  task automatic test_zero_len();
    int d0;
    d0 = done_cnt;
    start_dl();
    dl = 1'b0;
    wait_done("zero");
    n_chk++;
    if (cart_mask !== 22'd0 || romhdr !== 1'b0 || byte_cnt !== 25'd0) begin
      n_fail++; $display("FAIL zero state: mask=%h romhdr=%b cnt=%0d want 0/0/0", cart_mask, romhdr, byte_cnt);
    end
    n_chk++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero done pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_overrun();
    int t0, k;
    t0 = tog; k = 0;
    start_dl();
    wr = 1'b1; dout = 8'hAA;
    @(negedge clk_sys);
    n_chk++;
    if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL ovr wait: got %b want 1", ioctl_wait); end
    dout = 8'h55;                      // second strobe while stalled
    @(negedge clk_sys);
    wr = 1'b0;
    while (ioctl_wait && k < 100) begin @(negedge clk_sys); k++; end
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL ovr err: got %b want 1", err); end
    n_chk++;
    if (byte_cnt !== 25'd1) begin n_fail++; $display("FAIL ovr byte_cnt: got %0d want 1", byte_cnt); end
    n_chk++;
    if (tog - t0 != 1 || last_din !== 8'hAA) begin
      n_fail++; $display("FAIL ovr toggles: got %0d din=%h want 1 aa", tog - t0, last_din);
    end
    dl = 1'b0;
    wait_done("ovr");
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL ovr err sticky: got %b want 1", err); end
  endtask

  task automatic test_drain();
    int bad, k, hcnt, d0;
    d0 = done_cnt; k = 0; hcnt = 0;
    ack_dly = 5;
    start_dl();
    send_n(1, bad);
    // byte strobed in the same cycle download falls
    wr = 1'b1; dout = 8'hC3; dl = 1'b0;
    @(negedge clk_sys);
    wr = 1'b0;
    n_chk++;
    if (ioctl_wait !== 1'b1 || mem_din !== 8'hC3 || mem_waddr !== 24'd1) begin
      n_fail++; $display("FAIL drain write: wait=%b din=%h waddr=%h want 1 c3 1", ioctl_wait, mem_din, mem_waddr);
    end
    while (ack !== mem_we && k < 50) begin @(negedge clk_sys); k++; end
    @(negedge clk_sys);
    n_chk++;
    if (ioctl_wait !== 1'b0 || sys_reset !== 1'b1) begin
      n_fail++; $display("FAIL drain ack+1: wait=%b sys_reset=%b want 0 1", ioctl_wait, sys_reset);
    end
    while (sys_reset && hcnt < 100) begin hcnt++; @(negedge clk_sys); end
    n_chk++;
    if (hcnt != 16) begin n_fail++; $display("FAIL drain hold: got %0d cycles want 16", hcnt); end
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL drain done: got %b want 1", done); end
    @(negedge clk_sys);
    n_chk++;
    if (byte_cnt !== 25'd2 || err !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL drain result: cnt=%0d err=%b pulses=%0d want 2 0 1", byte_cnt, err, done_cnt - d0);
    end
    ack_dly = 3;
  endtask

  task automatic test_restart();
    int bad, d0;
    d0 = done_cnt;
    start_dl();
    send_n(2, bad);
    dl = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_chk++;
    if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL rst hold sys_reset: got %b want 1", sys_reset); end
    start_dl();                         // new edge during HOLD
    n_chk++;
    if (byte_cnt !== 25'd0 || done_cnt != d0) begin
      n_fail++; $display("FAIL rst restart: cnt=%0d pulses=%0d want 0 0", byte_cnt, done_cnt - d0);
    end
    send_n(3, bad);
    dl = 1'b0;
    wait_done("rst");
    n_chk++;
    if (bad != 0 || byte_cnt !== 25'd3 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL rst result: bad=%0d cnt=%0d pulses=%0d want 0 3 1", bad, byte_cnt, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    start_dl();
    wr = 1'b1; dout = 8'h11;
    @(negedge clk_sys);
    wr = 1'b0;
    RESET_n = 1'b0; dl = 1'b0;
    #1;
    n_chk++;
    if ({ioctl_wait, mem_we, romhdr, err, done, sys_reset} !== 6'b0 || mem_waddr !== 24'd0 ||
        mem_din !== 8'd0 || cart_mask !== 22'd0 || byte_cnt !== 25'd0) begin
      n_fail++; $display("FAIL midrst outputs: wait=%b we=%b sr=%b din=%h cnt=%0d want all 0",
                         ioctl_wait, mem_we, sys_reset, mem_din, byte_cnt);
    end
    @(negedge clk_sys);
    RESET_n = 1'b1;
    @(negedge clk_sys);
    start_dl();
    send_n(16, bad);
    dl = 1'b0;
    wait_done("midrst");
    n_chk++;
    if (bad != 0 || byte_cnt !== 25'd16 || cart_mask !== 22'hF || err !== 1'b0) begin
      n_fail++; $display("FAIL midrst rerun: bad=%0d cnt=%0d mask=%h err=%b want 0 16 f 0", bad, byte_cnt, cart_mask, err);
    end
  endtask

  task automatic test_overflow();
    int t0, k;
    t0 = tog4; k = 0;
    dl4 = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < 17; i++) begin
      int j;
      j = 0;
      wr4 = 1'b1; dout4 = 8'(i);
      @(negedge clk_sys);
      wr4 = 1'b0;
      while (wait4 && j < 100) begin @(negedge clk_sys); j++; end
    end
    n_chk++;
    if (cnt4 !== 25'd16 || err4 !== 1'b1) begin
      n_fail++; $display("FAIL ovf cnt/err: cnt=%0d err=%b want 16 1", cnt4, err4);
    end
    n_chk++;
    if (mask4 !== 4'hF || waddr4 !== 24'd16) begin
      n_fail++; $display("FAIL ovf mask/waddr: mask=%h waddr=%h want f 10", mask4, waddr4);
    end
    n_chk++;
    if (tog4 - t0 != 16) begin n_fail++; $display("FAIL ovf toggles: got %0d want 16", tog4 - t0); end
    dl4 = 1'b0;
    while (!done4 && k < 200) begin @(negedge clk_sys); k++; end
    n_chk++;
    if (done4 !== 1'b1) begin n_fail++; $display("FAIL ovf done: got %b want 1", done4); end
  endtask

  initial begin
    test_reset();
    test_1024();
    test_header();
    test_zero_len();
    test_overrun();
    test_drain();
    test_restart();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
